llc_mem_arbiter: RTL and testbench

//  Two-client arbiter placed upstream of the 256-bit line/burst adaptor.

---
 rtl/llc_mem_arbiter.sv | 101 ++++++++++
 tb/tb_llc_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/llc_mem_arbiter.sv
// Two-client (I-cache / D-cache) round-robin arbiter in front of the line adaptor.
// One whole-line transaction at a time; the granted request is latched so the downstream port is stable.
module llc_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_e state, state_nxt;
    req_t   req_q;
    logic   last_grant;   // 0 = I-cache, 1 = D-cache
    logic   i_req, d_req, grant_i, grant_d, serving;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, the client that did not win last time gets the line.
                grant_i = i_req && (!d_req || last_grant);
                grant_d = d_req && (!i_req || !last_grant);
                if (grant_i)      state_nxt = SERVE_I;
                else if (grant_d) state_nxt = SERVE_D;
            end
            SERVE_I: if (mem_resp) begin
                i_resp    = 1'b1;
                state_nxt = DONE;
            end
            SERVE_D: if (mem_resp) begin
                d_resp    = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q      <= '0;
            last_grant <= 1'b1;
        end else if (grant_i) begin
            req_q.wr   <= 1'b0;
            req_q.addr <= i_addr & ADDR_MASK;
            last_grant <= 1'b0;
        end else if (grant_d) begin
            // Simultaneous read+write from the D-cache is treated as a write.
            req_q.wr   <= d_write;
            req_q.addr <= d_addr & ADDR_MASK;
            if (d_write) req_q.wdata <= d_wdata;
            last_grant <= 1'b1;
        end
    end

    assign serving   = (state == SERVE_I) || (state == SERVE_D);
    assign mem_read  = serving & ~req_q.wr;
    assign mem_write = serving &  req_q.wr;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_llc_mem_arbiter.sv
// Directed bench for llc_mem_arbiter: grant order, latching, resp gating and reset.
module tb_llc_mem_arbiter;
    logic         clk, reset_n;
    logic         i_read, d_read, d_write, mem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
    logic         i_resp, d_resp, mem_read, mem_write;
    logic [31:0]  mem_addr;

    int checks = 0;
    int failures = 0;

    localparam logic [255:0] PAT_A = {8{32'hA5A5_0001}};
    localparam logic [255:0] PAT_B = {8{32'hBEEF_0B0B}};
    localparam logic [255:0] PAT_C = {8{32'hC0DE_0C0C}};
    localparam logic [255:0] PAT_D = {8{32'h1234_5678}};

    llc_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd"}, mem_read, 1'b0);
        chk({tag, "_wr"}, mem_write, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        do_reset();

        // reset state
        chk_idle("rst");
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_iresp", i_resp, 1'b0);
        chk("rst_dresp", d_resp, 1'b0);

        // 1: single I-cache fill
        i_read = 1; i_addr = 32'h0000_0064;
        tick();
        chk("t1_rd", mem_read, 1'b1);
        chk("t1_addr", mem_addr, 32'h0000_0060);
        tick();
        chk("t1_rd_hold", mem_read, 1'b1);
        chk("t1_addr_hold", mem_addr, 32'h0000_0060);
        mem_rdata = PAT_A; mem_resp = 1; #1;
        chk("t1_iresp", i_resp, 1'b1);
        chk("t1_idata", i_rdata, PAT_A);
        chk("t1_dresp", d_resp, 1'b0);
        tick();
        mem_resp = 0; i_read = 0;
        chk("t1_rd_drop", mem_read, 1'b0);
        chk("t1_iresp_drop", i_resp, 1'b0);
        tick();

        // 2: tie alternation, requests held
        do_reset();
        i_read = 1; i_addr = 32'h0000_1000;
        d_read = 1; d_addr = 32'h0000_2000;
        tick();
        chk("t2_g1_addr", mem_addr, 32'h0000_1000);
        chk("t2_g1_rd", mem_read, 1'b1);
        mem_resp = 1; #1;
        chk("t2_g1_iresp", i_resp, 1'b1);
        chk("t2_g1_dresp", d_resp, 1'b0);
        tick(); mem_resp = 0;
        chk_idle("t2_done1");
        tick();
        chk_idle("t2_idle1");
        tick();
        chk("t2_g2_addr", mem_addr, 32'h0000_2000);
        chk("t2_g2_rd", mem_read, 1'b1);
        mem_rdata = PAT_D; mem_resp = 1; #1;
        chk("t2_g2_dresp", d_resp, 1'b1);
        chk("t2_g2_iresp", i_resp, 1'b0);
        chk("t2_g2_ddata", d_rdata, PAT_D);
        tick(); mem_resp = 0;
        tick();
        tick();
        chk("t2_g3_addr", mem_addr, 32'h0000_1000);
        mem_resp = 1; #1;
        chk("t2_g3_iresp", i_resp, 1'b1);
        tick(); mem_resp = 0;
        tick();
        tick();
        chk("t2_g4_addr", mem_addr, 32'h0000_2000);
        mem_resp = 1; #1;
        chk("t2_g4_dresp", d_resp, 1'b1);
        tick(); mem_resp = 0; i_read = 0; d_read = 0;
        tick();

        // 3: writeback, wdata latched at grant
        do_reset();
        d_write = 1; d_addr = 32'h0000_0100; d_wdata = PAT_B;
        tick();
        d_wdata = PAT_C; d_addr = 32'h0000_0FFF;
        tick();
        chk("t3_wr", mem_write, 1'b1);
        chk("t3_rd", mem_read, 1'b0);
        chk("t3_addr", mem_addr, 32'h0000_0100);
        chk("t3_wdata", mem_wdata, PAT_B);
        mem_resp = 1; #1;
        chk("t3_dresp", d_resp, 1'b1);
        chk("t3_iresp", i_resp, 1'b0);
        tick(); mem_resp = 0; d_write = 0;
        chk("t3_dresp_once", d_resp, 1'b0);
        chk_idle("t3_done");
        tick();

        // 4: mem_resp in IDLE and DONE is ignored
        mem_resp = 1; #1;
        chk("t4_idle_iresp", i_resp, 1'b0);
        chk("t4_idle_dresp", d_resp, 1'b0);
        tick(); mem_resp = 0;
        chk_idle("t4_idle_stay");
        i_read = 1; i_addr = 32'h0000_0340;
        tick();
        chk("t4_rd", mem_read, 1'b1);
        mem_resp = 1; #1;
        chk("t4_iresp", i_resp, 1'b1);
        tick(); i_read = 0; #1;
        chk("t4_done_iresp", i_resp, 1'b0);
        chk("t4_done_dresp", d_resp, 1'b0);
        tick(); mem_resp = 0;
        chk_idle("t4_after_done");
        tick();
        chk_idle("t4_still_idle");

        // 5: read+write together is a write
        d_read = 1; d_write = 1; d_addr = 32'h0000_0480; d_wdata = PAT_C;
        tick();
        chk("t5_wr", mem_write, 1'b1);
        chk("t5_rd", mem_read, 1'b0);
        chk("t5_wdata", mem_wdata, PAT_C);
        mem_resp = 1; #1;
        chk("t5_dresp", d_resp, 1'b1);
        tick(); mem_resp = 0; d_read = 0; d_write = 0;
        tick();

        // 6: reset while serving the D-cache
        d_read = 1; d_addr = 32'h0000_05A0;
        tick();
        chk("t6_rd", mem_read, 1'b1);
        reset_n = 0;
        tick();
        reset_n = 1; d_read = 0;
        chk_idle("t6_rst");
        chk("t6_addr", mem_addr, 32'h0);
        mem_resp = 1; #1;
        chk("t6_dresp", d_resp, 1'b0);
        tick(); mem_resp = 0;
        tick();
        chk_idle("t6_quiet");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
